// File: rtl/ssp_uart_pkg.sv
// Shared constants and types for the SSP/UART transmit and receive FIFOs.
package ssp_uart_pkg;

    localparam int unsigned TF_DEPTH = 16;
    localparam int unsigned TF_DW    = 8;
    localparam int unsigned TF_CW    = 5;

    typedef logic [7:0] tf_data_t;
    typedef logic [4:0] tf_cnt_t;
    typedef logic [3:0] tf_ptr_t;

endpackage

// File: rtl/ssp_uart_fifo_ram.sv
// DEPTH x DW register file: one synchronous write port, one asynchronous read port.
// Shared by the transmit and receive FIFOs; contents are deliberately not reset.
module ssp_uart_fifo_ram
    import ssp_uart_pkg::*;
#(
    parameter int unsigned DEPTH = TF_DEPTH,
    parameter int unsigned DW    = TF_DW,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_uart_tx_fifo.sv
// Transmit FIFO between the SSP register write path and the UART serializer (FWFT).
// Optional sticky overflow/underflow flag TErr is built when SSP_UART_TF_ERR_EN is defined.
module ssp_uart_tx_fifo
    import ssp_uart_pkg::*;
#(
    parameter int unsigned DEPTH = TF_DEPTH,
    parameter int unsigned DW    = TF_DW,
    parameter int unsigned CW    = TF_CW,
    parameter int unsigned THRW  = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            TFC,
    input  logic            WE,
    input  logic [DW-1:0]   DI,
    input  logic            RE,
    output logic [DW-1:0]   DO,
    output logic            EF,
    output logic            T_FF,
    output logic [CW-1:0]   tcnt,
    input  logic [THRW-1:0] TFThr,
    output logic            iTFE,
    output logic            iTHE
`ifdef SSP_UART_TF_ERR_EN
    ,
    output logic            TErr
`endif
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CMPW = (CW > THRW) ? CW : THRW;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_acc, rd_acc;
    logic [DW-1:0] rd_data;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        rd_acc = RE && !EF;
        // A full FIFO still takes a write when the head is popped on the same edge.
        wr_acc = WE && (!T_FF || rd_acc);
        if (TFC) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                cnt_d = cnt_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    ssp_uart_fifo_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (Clk),
        .we    (wr_acc && !TFC),
        .waddr (wptr_q),
        .wdata (DI),
        .raddr (rptr_q),
        .rdata (rd_data)
    );

    assign tcnt = cnt_q;
    assign EF   = (cnt_q == '0);
    assign T_FF = (cnt_q == CW'(DEPTH));
    assign DO   = EF ? '0 : rd_data;
    assign iTFE = EF;
    assign iTHE = (CMPW'(cnt_q) <= CMPW'(TFThr));

`ifdef SSP_UART_TF_ERR_EN
    logic err_q, err_d;

    // Clear wins over a same-cycle error event.
    always_comb begin
        err_d = err_q;
        if (TFC) begin
            err_d = 1'b0;
        end else if ((WE && T_FF && !RE) || (RE && EF)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign TErr = err_q;
`endif

endmodule

// File: tb/tb_ssp_uart_tx_fifo.sv
// Randomized self-checking bench for ssp_uart_tx_fifo against a queue-based model.
module tb_ssp_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       TFC = 1'b0;
    logic       WE  = 1'b0;
    logic       RE  = 1'b0;
    logic [7:0] DI  = 8'h00;
    logic [7:0] TFThr = 8'd8;
    logic [7:0] DO;
    logic       EF, T_FF, iTFE, iTHE;
    logic [4:0] tcnt;
`ifdef SSP_UART_TF_ERR_EN
    logic       TErr;
`endif

    int total = 0;
    int bad   = 0;
    byte unsigned q[$];
    logic err_m = 1'b0;

    ssp_uart_tx_fifo dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .TFC   (TFC),
        .WE    (WE),
        .DI    (DI),
        .RE    (RE),
        .DO    (DO),
        .EF    (EF),
        .T_FF  (T_FF),
        .tcnt  (tcnt),
        .TFThr (TFThr),
        .iTFE  (iTFE),
        .iTHE  (iTHE)
`ifdef SSP_UART_TF_ERR_EN
        ,
        .TErr  (TErr)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] exp_do();
        return (q.size() == 0) ? 8'h00 : q[0];
    endfunction

    function automatic logic exp_the();
        return q.size() <= int'(TFThr);
    endfunction

    // One clock: drive inputs, let the edge happen, update the model, release strobes.
    task automatic step(input logic we, input logic [7:0] di, input logic re, input logic tfc);
        bit full, empty, rd, wr;
        WE = we; DI = di; RE = re; TFC = tfc;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        @(posedge Clk);
        #1;
        if (tfc) begin
            q.delete();
            err_m = 1'b0;
        end else begin
            rd = re && !empty;
            wr = we && (!full || rd);
            if ((we && full && !re) || (re && empty)) err_m = 1'b1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(di);
        end
        WE = 1'b0; RE = 1'b0; TFC = 1'b0;
    endtask

    task automatic test_reset();
        TFThr = 8'd8;
        #12;
        total++; if (EF !== 1'b1)    begin bad++; $display("FAIL reset_ef got=%b exp=1", EF); end
        total++; if (T_FF !== 1'b0)  begin bad++; $display("FAIL reset_ff got=%b exp=0", T_FF); end
        total++; if (tcnt !== 5'd0)  begin bad++; $display("FAIL reset_cnt got=%0d exp=0", tcnt); end
        total++; if (iTFE !== 1'b1)  begin bad++; $display("FAIL reset_itfe got=%b exp=1", iTFE); end
        total++; if (iTHE !== 1'b1)  begin bad++; $display("FAIL reset_ithe got=%b exp=1", iTHE); end
        total++; if (DO !== 8'h00)   begin bad++; $display("FAIL reset_do got=%h exp=00", DO); end
`ifdef SSP_UART_TF_ERR_EN
        total++; if (TErr !== 1'b0)  begin bad++; $display("FAIL reset_terr got=%b exp=0", TErr); end
`endif
        Rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        total++; if (EF !== 1'b1 || tcnt !== 5'd0) begin
            bad++; $display("FAIL idle got ef=%b cnt=%0d exp ef=1 cnt=0", EF, tcnt);
        end
    endtask

    task automatic test_two_writes();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        total++; if (DO !== 8'hA5) begin bad++; $display("FAIL first_word got=%h exp=a5", DO); end
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        total++; if (tcnt !== 5'd2 || EF !== 1'b0) begin
            bad++; $display("FAIL two_writes got cnt=%0d ef=%b exp cnt=2 ef=0", tcnt, EF);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (DO !== 8'h3C || tcnt !== 5'd1) begin
            bad++; $display("FAIL pop_one got do=%h cnt=%0d exp do=3c cnt=1", DO, tcnt);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (EF !== 1'b1) begin bad++; $display("FAIL drain_two got ef=%b exp=1", EF); end
    endtask

    task automatic test_fill_drain();
        TFThr = 8'd4;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            total++; if (tcnt !== 5'(i + 1) || iTHE !== ((i + 1) <= 4)) begin
                bad++; $display("FAIL fill_%0d got cnt=%0d ithe=%b exp cnt=%0d ithe=%b",
                                i, tcnt, iTHE, i + 1, (i + 1) <= 4);
            end
        end
        total++; if (T_FF !== 1'b1 || tcnt !== 5'd16) begin
            bad++; $display("FAIL full got ff=%b cnt=%0d exp ff=1 cnt=16", T_FF, tcnt);
        end
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        total++; if (tcnt !== 5'd16 || DO !== 8'h00) begin
            bad++; $display("FAIL overflow_drop got cnt=%0d do=%h exp cnt=16 do=00", tcnt, DO);
        end
`ifdef SSP_UART_TF_ERR_EN
        total++; if (TErr !== 1'b1) begin bad++; $display("FAIL overflow_terr got=%b exp=1", TErr); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (DO !== 8'(i)) begin
                bad++; $display("FAIL drain_%0d got=%h exp=%h", i, DO, 8'(i));
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
            total++; if (iTHE !== ((DEPTH - 1 - i) <= 4)) begin
                bad++; $display("FAIL drain_ithe_%0d got=%b exp=%b", i, iTHE, (DEPTH - 1 - i) <= 4);
            end
        end
        total++; if (EF !== 1'b1) begin bad++; $display("FAIL drained_ef got=%b exp=1", EF); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        total++; if (tcnt !== 5'd16 || DO !== exp_do()) begin
            bad++; $display("FAIL full_rw got cnt=%0d do=%h exp cnt=16 do=%h", tcnt, DO, exp_do());
        end
        for (int i = 0; i < DEPTH; i++) begin
            total++; if (DO !== exp_do() || (i == DEPTH - 1 && DO !== 8'h77)) begin
                bad++; $display("FAIL full_rw_read_%0d got=%h exp=%h", i, DO, exp_do());
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear_wrap();
        for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b1);
        total++; if (tcnt !== 5'd0 || EF !== 1'b1 || DO !== 8'h00) begin
            bad++; $display("FAIL clear got cnt=%0d ef=%b do=%h exp cnt=0 ef=1 do=00", tcnt, EF, DO);
        end
`ifdef SSP_UART_TF_ERR_EN
        total++; if (TErr !== 1'b0) begin bad++; $display("FAIL clear_terr got=%b exp=0", TErr); end
`endif
        for (int i = 0; i < 20; i++) begin
            logic [7:0] v;
            v = 8'($urandom_range(0, 255));
            step(1'b1, v, 1'b0, 1'b0);
            total++; if (DO !== v || tcnt !== 5'd1) begin
                bad++; $display("FAIL wrap_%0d got do=%h cnt=%0d exp do=%h cnt=1", i, DO, tcnt, v);
            end
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++; if (EF !== 1'b1) begin bad++; $display("FAIL wrap_end_ef got=%b exp=1", EF); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if (n % 50 == 0) TFThr = 8'($urandom_range(0, 20));
            step(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 63) == 0));
            total++; if (DO !== exp_do() || tcnt !== 5'(q.size()) || EF !== (q.size() == 0) ||
                         T_FF !== (q.size() == DEPTH) || iTFE !== (q.size() == 0) ||
                         iTHE !== exp_the()) begin
                bad++; $display("FAIL rand_%0d got do=%h cnt=%0d ef=%b ff=%b ithe=%b exp do=%h cnt=%0d ithe=%b",
                                n, DO, tcnt, EF, T_FF, iTHE, exp_do(), q.size(), exp_the());
            end
`ifdef SSP_UART_TF_ERR_EN
            total++; if (TErr !== err_m) begin
                bad++; $display("FAIL rand_terr_%0d got=%b exp=%b", n, TErr, err_m);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        TFThr = 8'd1;
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        #2 Rst = 1'b0;
        #1;
        q.delete();
        err_m = 1'b0;
        total++; if (EF !== 1'b1 || tcnt !== 5'd0 || DO !== 8'h00 || T_FF !== 1'b0 ||
                     iTFE !== 1'b1 || iTHE !== 1'b1) begin
            bad++; $display("FAIL async_reset got ef=%b cnt=%0d do=%h ff=%b itfe=%b ithe=%b exp 1 0 00 0 1 1",
                            EF, tcnt, DO, T_FF, iTFE, iTHE);
        end
`ifdef SSP_UART_TF_ERR_EN
        total++; if (TErr !== 1'b0) begin bad++; $display("FAIL async_terr got=%b exp=0", TErr); end
`endif
        #1 Rst = 1'b1;
        step(1'b1, 8'h9E, 1'b0, 1'b0);
        total++; if (DO !== 8'h9E || tcnt !== 5'd1) begin
            bad++; $display("FAIL post_reset got do=%h cnt=%0d exp do=9e cnt=1", DO, tcnt);
        end
    endtask

    initial begin
        test_reset();
        test_two_writes();
        test_fill_drain();
        test_full_rw();
        test_clear_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
